mult_product_accumulator: RTL and testbench

//   Downstream consumer of the 4-bit sequential multiplier. Captures each 8-bit

---
 rtl/mult_product_accumulator.sv | 125 ++++++++++++
 tb/tb_mult_product_accumulator.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mult_product_accumulator.sv
`default_nettype none
// ============================================================================
// mult_product_accumulator
// Sums batches of COUNT multiplier products and offers each batch sum on a
// valid/ready port. Optional macro SATURATE_EN clamps the sum on carry out.
// Revision 1.0
// ============================================================================
module mult_product_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 12,
  parameter int COUNT  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_done,
  input  logic              clear,
  output logic [ACC_W-1:0]  sum_out,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic              busy,
  output logic [7:0]        prod_cnt,
  output logic              overflow,
  output logic              overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(COUNT);
`ifdef SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MAX = '1;
`endif

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [7:0]       cnt;
  logic [ACC_W:0]   sum_wide;
  logic             carry;
  logic [ACC_W-1:0] acc_next;
  logic             start;
  logic             last;

  always_comb begin
    sum_wide = {1'b0, acc} + (ACC_W+1)'(prod_in);
    carry    = sum_wide[ACC_W];
`ifdef SATURATE_EN
    acc_next = carry ? ACC_MAX : sum_wide[ACC_W-1:0];
`else
    acc_next = sum_wide[ACC_W-1:0];
`endif
    // A product that arrives with the handshake opens the next batch at once.
    start = prod_done && ((state == S_IDLE) || ((state == S_HOLD) && sum_ready));
    last  = (cnt + 8'd1) == CNT_LAST;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state     <= S_IDLE;
      acc       <= '0;
      cnt       <= '0;
      sum_valid <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (start) begin
        acc      <= ACC_W'(prod_in);
        cnt      <= 8'd1;
        overflow <= 1'b0;
        if (COUNT == 1) begin
          state     <= S_HOLD;
          sum_valid <= 1'b1;
          busy      <= 1'b0;
        end else begin
          state     <= S_ACCUM;
          sum_valid <= 1'b0;
          busy      <= 1'b1;
        end
      end else begin
        case (state)
          S_IDLE: ;
          S_ACCUM: begin
            if (prod_done) begin
              acc <= acc_next;
              cnt <= cnt + 8'd1;
              if (carry) overflow <= 1'b1;
              if (last) begin
                state     <= S_HOLD;
                sum_valid <= 1'b1;
                busy      <= 1'b0;
              end
            end
          end
          S_HOLD: begin
            if (sum_ready) begin
              state     <= S_IDLE;
              sum_valid <= 1'b0;
              acc       <= '0;
              cnt       <= '0;
            end else if (prod_done) begin
              overrun <= 1'b1;
            end
          end
          default: begin
            state     <= S_IDLE;
            acc       <= '0;
            cnt       <= '0;
            sum_valid <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sum_out  = acc;
  assign prod_cnt = cnt;

endmodule
`default_nettype wire

// File: tb/tb_mult_product_accumulator.sv
`default_nettype none
// ============================================================================
// tb_mult_product_accumulator
// Directed plus random stimulus against a batch-level model (ACC_W=9, COUNT=4).
// Revision 1.0
// ============================================================================
module tb_mult_product_accumulator;

  localparam int PROD_W = 8;
  localparam int ACC_W  = 9;
  localparam int COUNT  = 4;
  localparam int MAXV   = (1 << ACC_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [PROD_W-1:0] prod_in = '0;
  logic              prod_done = 1'b0;
  logic              clear = 1'b0;
  logic [ACC_W-1:0]  sum_out;
  logic              sum_valid;
  logic              sum_ready = 1'b0;
  logic              busy;
  logic [7:0]        prod_cnt;
  logic              overflow;
  logic              overrun;

  int checks = 0;
  int failures = 0;

  // Model: the products of the open batch, whether a sum is pending, sticky overflow.
  int unsigned q[$];
  bit          m_valid = 1'b0;
  bit          m_ovf = 1'b0;
  bit          m_overrun = 1'b0;

  mult_product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .COUNT(COUNT)) dut (
    .clk(clk), .reset(reset), .prod_in(prod_in), .prod_done(prod_done),
    .clear(clear), .sum_out(sum_out), .sum_valid(sum_valid),
    .sum_ready(sum_ready), .busy(busy), .prod_cnt(prod_cnt),
    .overflow(overflow), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic int unsigned total();
    int unsigned t = 0;
    foreach (q[i]) t += q[i];
    return t;
  endfunction

  function automatic int unsigned exp_sum();
    int unsigned t = total();
`ifdef SATURATE_EN
    return (t > MAXV) ? MAXV : t;
`else
    return t % (MAXV + 1);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic add_product(input int unsigned p);
    if (q.size() == 0) m_ovf = 1'b0;
    q.push_back(p);
    if (total() > MAXV) m_ovf = 1'b1;
    m_valid = (q.size() == COUNT);
  endtask

  task automatic model_step(input bit r, input bit c, input bit pd, input int unsigned p, input bit rdy);
    m_overrun = 1'b0;
    if (r || c) begin
      q.delete();
      m_valid = 1'b0;
      m_ovf = 1'b0;
    end else if (m_valid) begin
      if (rdy) begin
        q.delete();
        m_valid = 1'b0;
        if (pd) add_product(p);
      end else if (pd) begin
        m_overrun = 1'b1;
      end
    end else if (pd) begin
      add_product(p);
    end
  endtask

  task automatic cycle(input bit r, input bit c, input bit pd, input int unsigned p, input bit rdy);
    reset = r; clear = c; prod_done = pd; prod_in = PROD_W'(p); sum_ready = rdy;
    @(posedge clk);
    model_step(r, c, pd, p, rdy);
    #1;
    chk("sum_valid", 32'(sum_valid), 32'(m_valid));
    chk("sum_out", 32'(sum_out), exp_sum());
    chk("prod_cnt", 32'(prod_cnt), q.size());
    chk("busy", 32'(busy), 32'(!m_valid && q.size() != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("overrun", 32'(overrun), 32'(m_overrun));
  endtask

  task automatic strobe(input int unsigned p);
    cycle(0, 0, 1, p, 0);
    cycle(0, 0, 0, 0, 0);
  endtask

  initial begin
    int unsigned sat_exp;
`ifdef SATURATE_EN
    sat_exp = 511;
`else
    sat_exp = 508;
`endif
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, 77, 1);
    chk("reset_sum", 32'(sum_out), 0);

    // Basic batch 3,5,7,9
    cycle(0, 0, 1, 3, 0); chk("t1_cnt1", 32'(prod_cnt), 1);
    cycle(0, 0, 1, 5, 0); chk("t1_cnt2", 32'(prod_cnt), 2);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 7, 0); chk("t1_cnt3", 32'(prod_cnt), 3);
    cycle(0, 0, 1, 9, 0);
    chk("t1_sum", 32'(sum_out), 24);
    chk("t1_valid", 32'(sum_valid), 1);
    chk("t1_cnt4", 32'(prod_cnt), 4);

    // Back-pressure, overrun in HOLD, then accept
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 'h11, 0);
    chk("t2_overrun", 32'(overrun), 1);
    chk("t2_sum", 32'(sum_out), 24);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    chk("t2_idle", 32'(sum_valid), 0);

    // Carry out of a 9-bit accumulator
    for (int i = 0; i < 4; i++) strobe(255);
    chk("t3_sum", 32'(sum_out), sat_exp);
    chk("t3_ovf", 32'(overflow), 1);
    cycle(0, 0, 0, 0, 1);
    chk("t3_ovf_sticky", 32'(overflow), 1);

    // Handshake and a new product in the same cycle
    for (int i = 1; i <= 4; i++) strobe(i);
    cycle(0, 0, 1, 6, 1);
    chk("t4_valid", 32'(sum_valid), 0);
    chk("t4_busy", 32'(busy), 1);
    chk("t4_sum", 32'(sum_out), 6);
    chk("t4_cnt", 32'(prod_cnt), 1);
    chk("t4_ovf", 32'(overflow), 0);
    for (int i = 0; i < 3; i++) strobe(1);
    cycle(0, 0, 0, 0, 1);

    // Clear mid-batch with a simultaneous strobe
    strobe(10); strobe(20);
    cycle(0, 1, 1, 30, 0);
    chk("t5_sum", 32'(sum_out), 0);
    chk("t5_overrun", 32'(overrun), 0);
    for (int i = 0; i < 4; i++) strobe(1);
    chk("t5_next", 32'(sum_out), 4);
    cycle(0, 0, 0, 0, 1);

    // Reset mid-batch
    for (int i = 0; i < 3; i++) strobe(40);
    cycle(1, 0, 0, 0, 0);
    chk("t6_cnt", 32'(prod_cnt), 0);
    for (int i = 0; i < 4; i++) strobe(2);
    chk("t6_sum", 32'(sum_out), 8);
    cycle(0, 0, 0, 0, 1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(99) < 2), ($urandom_range(99) < 3),
            ($urandom_range(99) < 50), $urandom_range(255),
            ($urandom_range(99) < 40));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
